// File: rtl/osc_clken_gen.sv
// Clock-enable generator (NUM_CH programmable tick strobes) with optional external
// oscillator monitor, present only when OSC_CLKMON_EN is defined.

module osc_clken_ch #(
   parameter int DIV_W   = 16,
   parameter int DIV_RST = 49
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             wr,
   input  logic [DIV_W-1:0] wdata,
   input  logic             restart,
   output logic             tick
);
   localparam logic [DIV_W-1:0] RST_V = DIV_W'(DIV_RST);

   logic [DIV_W-1:0] shadow, cnt, nxt_sh;
   logic             en_q;

   // A write in the same cycle as a reload is used by that reload.
   assign nxt_sh = wr ? wdata : shadow;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow <= RST_V;
         cnt    <= RST_V;
         en_q   <= 1'b0;
         tick   <= 1'b0;
      end else begin
         shadow <= nxt_sh;
         en_q   <= en;
         tick   <= 1'b0;
         if (!en) begin
            if (wr) cnt <= wdata;
         end else if (!en_q || restart) begin
            cnt <= nxt_sh;
         end else if (cnt == '0) begin
            cnt  <= nxt_sh;
            tick <= 1'b1;
         end else begin
            cnt <= cnt - DIV_W'(1);
         end
      end
   end
endmodule

module osc_clken_gen #(
   parameter int NUM_CH   = 4,
   parameter int DIV_W    = 16,
   parameter int DIV_RST  = 49,
   parameter int MON_WIN  = 1024,
   parameter int MON_MIN  = 400,
   parameter int MON_MAX  = 420,
   parameter int LOCK_CNT = 4
) (
   input  logic                         PCLK,
   input  logic                         PRESETN,
   input  logic [NUM_CH-1:0]            ch_en,
   input  logic [NUM_CH-1:0]            div_wr,
   input  logic [DIV_W-1:0]             div_wdata,
   input  logic                         sync_restart,
   output logic [NUM_CH-1:0]            tick,
   input  logic                         xtl_in,
   output logic                         xtl_ok,
   output logic                         xtl_lost,
   output logic [$clog2(MON_WIN+1)-1:0] xtl_edges
);
   localparam int EW = $clog2(MON_WIN+1);

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      osc_clken_ch #(.DIV_W(DIV_W), .DIV_RST(DIV_RST)) u_ch (
         .clk     (PCLK),
         .rst_n   (PRESETN),
         .en      (ch_en[i]),
         .wr      (div_wr[i]),
         .wdata   (div_wdata),
         .restart (sync_restart),
         .tick    (tick[i])
      );
   end

`ifdef OSC_CLKMON_EN
   localparam int WIN_W = (MON_WIN > 1) ? $clog2(MON_WIN) : 1;
   localparam int GW    = $clog2(LOCK_CNT+1);

   typedef enum logic [1:0] {WARMUP, LOCKED, LOST} mon_st_e;

   mon_st_e          state;
   logic             s1, s2, s3, rise, win_end, good;
   logic [WIN_W-1:0] win_cnt;
   logic [EW-1:0]    edge_cnt, win_edges;
   logic [GW-1:0]    good_cnt, good_nx;

   assign rise      = s2 & ~s3;
   assign win_end   = (win_cnt == WIN_W'(MON_WIN-1));
   // Running count including this cycle's edge, saturating at MON_WIN.
   assign win_edges = (rise && edge_cnt != EW'(MON_WIN)) ? edge_cnt + EW'(1) : edge_cnt;
   assign good      = (win_edges >= EW'(MON_MIN)) && (win_edges <= EW'(MON_MAX));
   assign good_nx   = (good_cnt == GW'(LOCK_CNT)) ? good_cnt : good_cnt + GW'(1);

   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) begin
         {s1, s2, s3} <= '0;
         win_cnt      <= '0;
         edge_cnt     <= '0;
         good_cnt     <= '0;
         state        <= WARMUP;
         xtl_ok       <= 1'b0;
         xtl_lost     <= 1'b0;
         xtl_edges    <= '0;
      end else begin
         s1       <= xtl_in;
         s2       <= s1;
         s3       <= s2;
         xtl_lost <= 1'b0;
         if (!win_end) begin
            win_cnt  <= win_cnt + WIN_W'(1);
            edge_cnt <= win_edges;
         end else begin
            win_cnt   <= '0;
            edge_cnt  <= '0;
            xtl_edges <= win_edges;
            case (state)
               LOCKED: if (!good) begin
                  state    <= LOST;
                  xtl_lost <= 1'b1;
                  xtl_ok   <= 1'b0;
                  good_cnt <= '0;
               end
               default: begin
                  if (!good) begin
                     good_cnt <= '0;
                  end else begin
                     good_cnt <= good_nx;
                     if (good_nx == GW'(LOCK_CNT)) begin
                        state  <= LOCKED;
                        xtl_ok <= 1'b1;
                     end
                  end
               end
            endcase
         end
      end
   end
`else
   logic unused_mon;
   assign unused_mon = ^{xtl_in, 1'(MON_MIN), 1'(MON_MAX), 1'(LOCK_CNT)};
   assign xtl_ok    = 1'b0;
   assign xtl_lost  = 1'b0;
   assign xtl_edges = '0;
`endif
endmodule

// File: tb/tb_osc_clken_gen.sv
// Scoreboard bench for osc_clken_gen: expected tick cycles and monitor checkpoints
// are queued when stimulus is driven and compared at each negedge.

module tb_osc_clken_gen;
   localparam int NUM_CH = 4;
   localparam int DIV_W  = 16;
   localparam int EW     = 11;

   logic              PCLK = 1'b0, PRESETN = 1'b0;
   logic [NUM_CH-1:0] ch_en = '0, div_wr = '0, tick;
   logic [DIV_W-1:0]  div_wdata = '0;
   logic              sync_restart = 1'b0, xtl_in = 1'b0, xtl_ok, xtl_lost;
   logic [EW-1:0]     xtl_edges;

   osc_clken_gen dut (
      .PCLK(PCLK), .PRESETN(PRESETN), .ch_en(ch_en), .div_wr(div_wr),
      .div_wdata(div_wdata), .sync_restart(sync_restart), .tick(tick),
      .xtl_in(xtl_in), .xtl_ok(xtl_ok), .xtl_lost(xtl_lost), .xtl_edges(xtl_edges)
   );

   always #10 PCLK = ~PCLK;

   int cyc = 0;
   always @(posedge PCLK) cyc <= cyc + 1;

   typedef struct {int cyc; int sel; logic [31:0] exp;} mon_exp_t;

   int       n_chk = 0, n_fail = 0;
   int       tick_q[NUM_CH][$];
   mon_exp_t mon_q[$];
   bit       tick_chk = 0, pat_on = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got %0h want %0h", tag, cyc, obs, exp);
      end
   endtask

   // 1024-cycle periodic pattern with exactly 410 rising edges per period
   function automatic logic pat_bit(input int c);
      int p = c % 1024;
      if (p < 1020) return ((p % 5) == 0) || ((p % 5) == 2) || ((p % 5) == 3);
      return (p == 1020) || (p == 1022);
   endfunction

   function automatic logic [31:0] mx(input logic [31:0] v);
`ifdef OSC_CLKMON_EN
      return v;
`else
      return 32'd0 & v;
`endif
   endfunction

   task automatic push_ticks(input int ch, input int first, input int per, input int last);
      for (int t = first; t <= last; t += per) tick_q[ch].push_back(t);
   endtask

   task automatic push_mon(input int c, input int sel, input logic [31:0] v);
      mon_exp_t e;
      e.cyc = c; e.sel = sel; e.exp = mx(v);
      mon_q.push_back(e);
   endtask

   task automatic clear_q();
      for (int i = 0; i < NUM_CH; i++) tick_q[i].delete();
      mon_q.delete();
   endtask

   task automatic step();
      bit ex;
      mon_exp_t e;
      @(negedge PCLK);
      if (tick_chk) begin
         for (int i = 0; i < NUM_CH; i++) begin
            ex = (tick_q[i].size() > 0) && (tick_q[i][0] == cyc);
            if (ex) void'(tick_q[i].pop_front());
            chk($sformatf("tick%0d", i), {31'd0, tick[i]}, {31'd0, ex});
         end
      end
      while (mon_q.size() > 0 && mon_q[0].cyc <= cyc) begin
         e = mon_q.pop_front();
         case (e.sel)
            0:       chk("xtl_ok", {31'd0, xtl_ok}, e.exp);
            1:       chk("xtl_lost", {31'd0, xtl_lost}, e.exp);
            default: chk("xtl_edges", {21'd0, xtl_edges}, e.exp);
         endcase
      end
      xtl_in = pat_on ? pat_bit(cyc) : 1'b0;
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   task automatic do_reset(output int r0);
      PRESETN = 1'b0; ch_en = '0; div_wr = '0; div_wdata = '0; sync_restart = 1'b0;
      tick_chk = 0;
      clear_q();
      run(3);
      PRESETN = 1'b1;
      r0 = cyc;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog @cyc %0d", cyc);
      $fatal(1);
   end

   initial begin
      int r0, n, a, b, c, s;

      // reset state
      run(2);
      chk("rst_tick", {28'd0, tick}, 32'd0);
      chk("rst_ok", {31'd0, xtl_ok}, 32'd0);
      chk("rst_lost", {31'd0, xtl_lost}, 32'd0);
      chk("rst_edges", {21'd0, xtl_edges}, 32'd0);

      // ch0 at reset divider: first tick 50 cycles after enable sampled
      do_reset(r0);
      step(); n = cyc;
      ch_en = 4'b0001; tick_chk = 1;
      push_ticks(0, n + 51, 50, n + 300);
      run(300);

      // divider rewrite mid-period, then div=0
      do_reset(r0);
      step(); n = cyc;
      ch_en = 4'b0001; tick_chk = 1;
      push_ticks(0, n + 51, 50, n + 101);
      run(70);
      div_wdata = 16'd9; div_wr = 4'b0001;
      push_ticks(0, n + 111, 10, n + 121);
      step(); div_wr = '0;
      run(44);
      div_wdata = 16'd0; div_wr = 4'b0001;
      push_ticks(0, n + 122, 1, n + 150);
      step(); div_wr = '0;
      run(34);

      // staggered channels re-phased by sync_restart
      do_reset(r0);
      step(); a = cyc; tick_chk = 1;
      div_wdata = 16'd4; div_wr = 4'b0001;
      step(); div_wdata = 16'd9; div_wr = 4'b0010;
      step(); div_wr = '0;
      run(3); b = cyc; s = b + 20;
      ch_en = 4'b0001; push_ticks(0, b + 6, 5, s);
      run(3); c = cyc;
      ch_en = 4'b0011; push_ticks(1, c + 11, 10, s);
      run(17);
      sync_restart = 1'b1;
      push_ticks(0, s + 6, 5, s + 50);
      push_ticks(1, s + 11, 10, s + 50);
      step(); sync_restart = 1'b0;
      run(49);
      chk("sync_left0", tick_q[0].size(), 0);

      // monitor: lock, loss on stuck input, relock
      pat_on = 1;
      do_reset(r0);
      push_mon(r0 + 2048, 2, 410);
      push_mon(r0 + 4095, 0, 0);
      push_mon(r0 + 4096, 0, 1);
      push_mon(r0 + 4096, 2, 410);
      push_mon(r0 + 4096, 1, 0);
      run(4093);
      pat_on = 0;
      push_mon(r0 + 5119, 0, 1);
      push_mon(r0 + 5119, 1, 0);
      push_mon(r0 + 5120, 1, 1);
      push_mon(r0 + 5120, 0, 0);
      push_mon(r0 + 5120, 2, 0);
      push_mon(r0 + 5121, 1, 0);
      run(5117 - 4093);
      pat_on = 1;
      push_mon(r0 + 6144, 1, 0);
      push_mon(r0 + 6144, 0, 0);
      push_mon(r0 + 9215, 0, 0);
      push_mon(r0 + 9216, 0, 1);
      push_mon(r0 + 9216, 2, 410);
      run(9220 - 5117);

      // async reset mid-window and mid-period, with ch1 ticking every cycle
      div_wdata = 16'd0; div_wr = 4'b0010;
      step(); div_wr = '0;
      ch_en = 4'b0011;
      run(120);
      chk("pre_rst_tick1", {31'd0, tick[1]}, 32'd1);
      chk("pre_rst_ok", {31'd0, xtl_ok}, mx(1));
      #3 PRESETN = 1'b0;
      #1 chk("rst_async", {16'd0, tick, xtl_ok, xtl_lost, xtl_edges}, 32'd0);
      run(3);
      chk("rst_hold", {16'd0, tick, xtl_ok, xtl_lost, xtl_edges}, 32'd0);
      PRESETN = 1'b1; r0 = cyc;
      clear_q();
      push_ticks(0, r0 + 51, 50, r0 + 4200);
      push_ticks(1, r0 + 51, 50, r0 + 4200);
      push_mon(r0 + 1024, 1, 0);
      push_mon(r0 + 4095, 0, 0);
      push_mon(r0 + 4096, 0, 1);
      push_mon(r0 + 4096, 2, 410);
      tick_chk = 1;
      run(4200);
      chk("mon_left", mon_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
